// File: rtl/rtc_disp_pkg.sv
// Shared definitions for the RTC display snapshot block:
// register address map, register count and FSM state encodings.
package rtc_disp_pkg;

    localparam int N_REGS = 9;

    localparam logic [7:0] ADDR_DIA      = 8'h24;
    localparam logic [7:0] ADDR_MES      = 8'h25;
    localparam logic [7:0] ADDR_ANO      = 8'h26;
    localparam logic [7:0] ADDR_HORA     = 8'h23;
    localparam logic [7:0] ADDR_MINUTO   = 8'h22;
    localparam logic [7:0] ADDR_SEGUNDO  = 8'h21;
    localparam logic [7:0] ADDR_HORAT    = 8'h43;
    localparam logic [7:0] ADDR_MINUTOT  = 8'h42;
    localparam logic [7:0] ADDR_SEGUNDOT = 8'h41;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        PEND  = 2'd3
    } state_t;

    // Shadow-bank index -> RTC register address.
    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        logic [7:0] a;
        case (idx)
            4'd0:    a = ADDR_DIA;
            4'd1:    a = ADDR_MES;
            4'd2:    a = ADDR_ANO;
            4'd3:    a = ADDR_HORA;
            4'd4:    a = ADDR_MINUTO;
            4'd5:    a = ADDR_SEGUNDO;
            4'd6:    a = ADDR_HORAT;
            4'd7:    a = ADDR_MINUTOT;
            default: a = ADDR_SEGUNDOT;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/rtc_bcd_sanitize.sv
// Combinational BCD sanitizer: any nibble above 9 becomes 4'hF (blank).
// Ports: i_data (raw byte), o_data (sanitized byte), o_err (a nibble was bad).
module rtc_bcd_sanitize (
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_err
);

    logic w_hi_bad;
    logic w_lo_bad;

    assign w_hi_bad = (i_data[7:4] > 4'd9);
    assign w_lo_bad = (i_data[3:0] > 4'd9);

    assign o_data[7:4] = w_hi_bad ? 4'hF : i_data[7:4];
    assign o_data[3:0] = w_lo_bad ? 4'hF : i_data[3:0];
    assign o_err       = w_hi_bad | w_lo_bad;

endmodule

// File: rtl/rtc_display_snapshot.sv
// Periodically scans 9 RTC registers into a shadow bank and commits the bank
// to the renderer BCD outputs only at frame start (VS falling edge).
// Also latches the alarm indicator. Optional macro ALARM_BLINK_EN makes the
// indicator blink every BLINK_FRAMES frames while latched.
// Ports: i_clk, i_rst (sync, active-high); read handshake o_rd_req/o_rd_addr/
// i_rd_ack/i_rd_data; i_vs (active-low vsync); i_alarm_irq/i_alarm_clr;
// o_*_t committed BCD bytes; o_alarma; o_snap_valid; o_bcd_err; o_rd_to_err.
module rtc_display_snapshot
    import rtc_disp_pkg::*;
#(
    parameter int SCAN_DIV = 1_000_000,
    parameter int TIMEOUT  = 16
`ifdef ALARM_BLINK_EN
    , parameter int BLINK_FRAMES = 30
`endif
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_rd_req,
    output logic [7:0] o_rd_addr,
    input  logic       i_rd_ack,
    input  logic [7:0] i_rd_data,
    input  logic       i_vs,
    input  logic       i_alarm_irq,
    input  logic       i_alarm_clr,
    output logic [7:0] o_dia_t,
    output logic [7:0] o_mes_t,
    output logic [7:0] o_ano_t,
    output logic [7:0] o_hora_t,
    output logic [7:0] o_minuto_t,
    output logic [7:0] o_segundo_t,
    output logic [7:0] o_horat_t,
    output logic [7:0] o_minutot_t,
    output logic [7:0] o_segundot_t,
    output logic       o_alarma,
    output logic       o_snap_valid,
    output logic       o_bcd_err,
    output logic       o_rd_to_err
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0] IDX_LAST = 4'(N_REGS - 1);

    state_t          r_state;
    logic [SW-1:0]   r_scan_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic [3:0]      r_idx;
    logic [7:0]      r_shadow [N_REGS];
    logic [7:0]      r_out    [N_REGS];
    logic            r_rd_req;
    logic [7:0]      r_rd_addr;
    logic            r_vs_q;
    logic            r_snap_valid;
    logic            r_bcd_err;
    logic            r_rd_to_err;
    logic            r_alarm;

    logic            w_tick;
    logic            w_vs_fall;
    logic [7:0]      w_san_data;
    logic            w_san_err;

    rtc_bcd_sanitize u_san (
        .i_data (i_rd_data),
        .o_data (w_san_data),
        .o_err  (w_san_err)
    );

    assign w_tick    = (r_scan_cnt == SCAN_LAST);
    assign w_vs_fall = r_vs_q & ~i_vs;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scan_cnt <= '0;
        end else if (w_tick) begin
            r_scan_cnt <= '0;
        end else begin
            r_scan_cnt <= r_scan_cnt + SW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vs_q <= 1'b0;
        end else begin
            r_vs_q <= i_vs;
        end
    end

    // Scan FSM. Ticks outside IDLE are simply not looked at (dropped).
    // The last ACK moves to PEND without checking VS, so a frame start on
    // that same edge never commits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_to_cnt     <= '0;
            r_rd_req     <= 1'b0;
            r_rd_addr    <= '0;
            r_snap_valid <= 1'b0;
            r_bcd_err    <= 1'b0;
            r_rd_to_err  <= 1'b0;
            for (int i = 0; i < N_REGS; i++) begin
                r_shadow[i] <= '0;
                r_out[i]    <= '0;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_rd_req  <= 1'b1;
                    r_rd_addr <= reg_addr(r_idx);
                    r_to_cnt  <= '0;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (i_rd_ack) begin
                        r_rd_req        <= 1'b0;
                        r_shadow[r_idx] <= w_san_data;
                        if (w_san_err) begin
                            r_bcd_err <= 1'b1;
                        end
                        if (r_idx == IDX_LAST) begin
                            r_idx   <= '0;
                            r_state <= PEND;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= ISSUE;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        r_rd_req    <= 1'b0;
                        r_rd_to_err <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
                end
                PEND: begin
                    if (w_vs_fall) begin
                        for (int i = 0; i < N_REGS; i++) begin
                            r_out[i] <= r_shadow[i];
                        end
                        r_snap_valid <= 1'b1;
                        r_idx        <= '0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Set has priority over clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_alarm <= 1'b0;
        end else if (i_alarm_irq) begin
            r_alarm <= 1'b1;
        end else if (i_alarm_clr) begin
            r_alarm <= 1'b0;
        end
    end

`ifdef ALARM_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] r_frame_cnt;
    logic          r_phase;

    // Phase restarts "on" at every set and is held off while clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (i_alarm_irq) begin
            r_frame_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (i_alarm_clr) begin
            r_frame_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_alarm && w_vs_fall) begin
            if (r_frame_cnt == BLINK_LAST) begin
                r_frame_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + BW'(1);
            end
        end
    end

    assign o_alarma = r_alarm & r_phase;
`else
    assign o_alarma = r_alarm;
`endif

    assign o_rd_req     = r_rd_req;
    assign o_rd_addr    = r_rd_addr;
    assign o_snap_valid = r_snap_valid;
    assign o_bcd_err    = r_bcd_err;
    assign o_rd_to_err  = r_rd_to_err;

    assign o_dia_t      = r_out[0];
    assign o_mes_t      = r_out[1];
    assign o_ano_t      = r_out[2];
    assign o_hora_t     = r_out[3];
    assign o_minuto_t   = r_out[4];
    assign o_segundo_t  = r_out[5];
    assign o_horat_t    = r_out[6];
    assign o_minutot_t  = r_out[7];
    assign o_segundot_t = r_out[8];

endmodule
